calendar_date_counter: RTL

- Sequential day/month/year calendar counter that advances one day per `day_tick`.
- Instantiates the existing combinational `days_counter` block:
  - drives it with the current month number and leap-year flag;
  - consumes its one-hot m28/m29/m30/m31 outputs to decide month rollover.
- Tracks the Gregorian leap rule incrementally through a running year-mod-400 residue.
- Supports synchronous date load with validation and multi-cycle residue recomputation.

---
 rtl/calendar_date_counter_pkg.sv | 39 +++
 rtl/calendar_date_counter_if.sv | 36 +++
 rtl/days_counter.sv | 33 +++
 rtl/calendar_date_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/calendar_date_counter_pkg.sv
// Shared constants, FSM encoding and helpers for the calendar date counter.
//   - Month constants and leap-rule constants (400-year cycle, century).
//   - state_e: RUN (counting) / REDUCE (recomputing year mod 400 after a load).
//   - month_len: turns the one-hot month-length decode into a day count.
//   - is_leap: Gregorian rule evaluated from year[1:0] and the year-mod-400 residue.
package calendar_date_counter_pkg;

  localparam int unsigned DEFAULT_YEAR_W = 12;

  localparam logic [3:0] MONTH_JAN = 4'd1;
  localparam logic [3:0] MONTH_FEB = 4'd2;
  localparam logic [3:0] MONTH_DEC = 4'd12;

  localparam logic [8:0] YEAR_CYCLE = 9'd400;
  localparam logic [8:0] CENTURY    = 9'd100;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StReduce = 1'b1
  } state_e;

  // Zero when no length is asserted, i.e. the month number was out of range.
  function automatic logic [4:0] month_len(logic m28, logic m29, logic m30, logic m31);
    logic [4:0] len;
    len = 5'd0;
    if (m28)      len = 5'd28;
    else if (m29) len = 5'd29;
    else if (m30) len = 5'd30;
    else if (m31) len = 5'd31;
    return len;
  endfunction

  // Divisible by 4, except centuries that are not multiples of 400.
  function automatic logic is_leap(logic [1:0] year_lo, logic [8:0] r400);
    return (year_lo == 2'b00) &&
           (r400 != CENTURY) && (r400 != (CENTURY * 9'd2)) && (r400 != (CENTURY * 9'd3));
  endfunction

endpackage

// File: rtl/calendar_date_counter_if.sv
// Date counter bus.
//   master: drives day_tick/load/load_day/load_month/load_year, observes the date and status.
//   slave : the counter; observes the controls, drives day/month/year/leap/busy and the
//           month_end/year_end/load_err pulses.
interface calendar_date_counter_if
  import calendar_date_counter_pkg::*;
#(
  parameter int unsigned YEAR_W = DEFAULT_YEAR_W
);

  logic              day_tick;
  logic              load;
  logic [4:0]        load_day;
  logic [3:0]        load_month;
  logic [YEAR_W-1:0] load_year;

  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic              busy;
  logic              month_end;
  logic              year_end;
  logic              load_err;

  modport master (
    output day_tick, load, load_day, load_month, load_year,
    input  day, month, year, leap, busy, month_end, year_end, load_err
  );

  modport slave (
    input  day_tick, load, load_day, load_month, load_year,
    output day, month, year, leap, busy, month_end, year_end, load_err
  );

endinterface

// File: rtl/days_counter.sv
// Month-length decoder (combinational).
//   m3..m0 : binary month number, MSB first (1..12 valid).
//   leap   : year is leap (selects 29 days for February).
//   m28..m31 : one-hot month length; all low for an out-of-range month.
module days_counter (
  input  logic m3,
  input  logic m2,
  input  logic m1,
  input  logic m0,
  input  logic leap,
  output logic m28,
  output logic m29,
  output logic m30,
  output logic m31
);

  always_comb begin
    m28 = 1'b0;
    m29 = 1'b0;
    m30 = 1'b0;
    m31 = 1'b0;
    case ({m3, m2, m1, m0})
      4'd2: begin
        m28 = ~leap;
        m29 = leap;
      end
      4'd4, 4'd6, 4'd9, 4'd11:                   m30 = 1'b1;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: m31 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year calendar counter advancing one day per day_tick.
//   clk   : clock, rising edge.
//   rst_n : synchronous active-low reset.
//   bus   : calendar_date_counter_if slave (tick/load controls in, date and status out).
// The Gregorian leap rule is tracked with a running year-mod-400 residue. A load sets
// the date at once and then spends floor(year/400)+1 cycles (busy) re-deriving the
// residue by repeated subtraction; ticks are dropped meanwhile and leap reads 0.
module calendar_date_counter
  import calendar_date_counter_pkg::*;
#(
  parameter int unsigned YEAR_W     = DEFAULT_YEAR_W,
  parameter int unsigned YEAR_RESET = 2000
) (
  input logic                    clk,
  input logic                    rst_n,
  calendar_date_counter_if.slave bus
);

  // Residue working register must hold at least 400.
  localparam int unsigned RemW = (YEAR_W > 9) ? YEAR_W : 9;

  localparam logic [YEAR_W-1:0] YearResetV = YEAR_W'(YEAR_RESET);
  localparam logic [8:0]        R400Reset  = 9'(YEAR_RESET % 400);
  localparam logic              LeapReset  = is_leap(YearResetV[1:0], R400Reset);

  state_e            state_q, state_d;
  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic [8:0]        r400_q, r400_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic              leap_q, leap_d;
  logic              month_end_q, month_end_d;
  logic              year_end_q, year_end_d;
  logic              load_err_q, load_err_d;

  // Length of the current month.
  logic cur_m28, cur_m29, cur_m30, cur_m31;
  logic [4:0] last_day;

  days_counter u_cur_len (
    .m3   (month_q[3]),
    .m2   (month_q[2]),
    .m1   (month_q[1]),
    .m0   (month_q[0]),
    .leap (leap_q),
    .m28  (cur_m28),
    .m29  (cur_m29),
    .m30  (cur_m30),
    .m31  (cur_m31)
  );

  assign last_day = month_len(cur_m28, cur_m29, cur_m30, cur_m31);

  // Load validation: February accepted up to 29; a non-leap 29th is clamped after REDUCE.
  logic ld_m28, ld_m29, ld_m30, ld_m31;
  logic [4:0] load_max;
  logic       load_ok;

  days_counter u_load_len (
    .m3   (bus.load_month[3]),
    .m2   (bus.load_month[2]),
    .m1   (bus.load_month[1]),
    .m0   (bus.load_month[0]),
    .leap (1'b1),
    .m28  (ld_m28),
    .m29  (ld_m29),
    .m30  (ld_m30),
    .m31  (ld_m31)
  );

  assign load_max = month_len(ld_m28, ld_m29, ld_m30, ld_m31);
  assign load_ok  = (bus.load_month >= MONTH_JAN) && (bus.load_month <= MONTH_DEC) &&
                    (bus.load_day != 5'd0) && (bus.load_day <= load_max);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      day_q       <= 5'd1;
      month_q     <= MONTH_JAN;
      year_q      <= YearResetV;
      r400_q      <= R400Reset;
      rem_q       <= '0;
      leap_q      <= LeapReset;
      month_end_q <= 1'b0;
      year_end_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      r400_q      <= r400_d;
      rem_q       <= rem_d;
      leap_q      <= leap_d;
      month_end_q <= month_end_d;
      year_end_q  <= year_end_d;
      load_err_q  <= load_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    r400_d      = r400_q;
    rem_d       = rem_q;
    month_end_d = 1'b0;
    year_end_d  = 1'b0;
    load_err_d  = 1'b0;

    unique case (state_q)
      StRun: begin
        // Any load request, valid or not, swallows a coincident tick.
        if (bus.day_tick && !bus.load) begin
          if (day_q < last_day) begin
            day_d = day_q + 5'd1;
          end else begin
            day_d       = 5'd1;
            month_end_d = 1'b1;
            if (month_q >= MONTH_DEC) begin
              month_d    = MONTH_JAN;
              year_end_d = 1'b1;
              if (year_q == '1) begin
                year_d = '0;
                r400_d = '0;
              end else begin
                year_d = year_q + YEAR_W'(1);
                r400_d = (r400_q == (YEAR_CYCLE - 9'd1)) ? 9'd0 : r400_q + 9'd1;
              end
            end else begin
              month_d = month_q + 4'd1;
            end
          end
        end
      end
      StReduce: begin
        if (rem_q >= RemW'(YEAR_CYCLE)) begin
          rem_d = rem_q - RemW'(YEAR_CYCLE);
        end else begin
          state_d = StRun;
          r400_d  = rem_q[8:0];
          if ((month_q == MONTH_FEB) && (day_q == 5'd29) && !is_leap(year_q[1:0], rem_q[8:0])) begin
            day_d      = 5'd28;
            load_err_d = 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase

    // A load overrides whatever the current state was doing, restarting any reduction.
    if (bus.load) begin
      if (load_ok) begin
        day_d      = bus.load_day;
        month_d    = bus.load_month;
        year_d     = bus.load_year;
        rem_d      = RemW'(bus.load_year);
        state_d    = StReduce;
        load_err_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end
  end

  // Leap is registered from next-state values so it is never stale after a transition.
  always_comb begin
    leap_d = (state_d == StRun) && is_leap(year_d[1:0], r400_d);
  end

  // Outputs.
  always_comb begin
    bus.day       = day_q;
    bus.month     = month_q;
    bus.year      = year_q;
    bus.leap      = leap_q;
    bus.busy      = (state_q == StReduce);
    bus.month_end = month_end_q;
    bus.year_end  = year_end_q;
    bus.load_err  = load_err_q;
  end

endmodule
